// File: rtl/counter_sequencer_pkg.sv
// Shared types and defaults for the counter sequencer slice.
// State encoding is fixed and visible on the state output.
package counter_sequencer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/counter_sequencer_core.sv
// Count register: synchronous clear, load, or single +/-1 step per edge.
// Clear has priority over load, load over step; otherwise the count holds.
module counter_core #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_step,
  input  logic             i_down,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!clear_n || i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_step) begin
      r_count <= i_down ? r_count - 1'b1 : r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/counter_sequencer.sv
// Counter sequencer: config registers, IDLE/RUN/HOLD/DONE FSM and Moore
// decode of busy/tick/done around a counter_core datapath.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_down,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_limit;
  logic             r_down;
  logic             r_periodic;

  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_term;
  logic [WIDTH-1:0] w_start_val;
  logic             w_at_term;
  logic             w_clr;
  logic             w_load;
  logic             w_step;
  logic             w_cfg_take;

  assign w_term      = r_down ? '0 : r_limit;
  assign w_start_val = r_down ? r_limit : '0;
  assign w_at_term   = (w_count == w_term);

  // Priority stop > pause > start > cfg_we; pause only freezes/blocks, never loads.
  always_comb begin
    w_next     = r_state;
    w_clr      = 1'b0;
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_cfg_take = 1'b0;
    if (stop) begin
      w_next = ST_IDLE;
      w_clr  = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start && !pause) begin
            w_next = ST_RUN;
            w_load = 1'b1;
          end else if (cfg_we) begin
            w_cfg_take = 1'b1;
          end
        end
        ST_RUN: begin
          if (pause) begin
            w_next = ST_HOLD;
          end else if (w_at_term) begin
            if (r_periodic) w_load = 1'b1;
            else            w_next = ST_DONE;
          end else begin
            w_step = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!pause) w_next = ST_RUN;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_state    <= ST_IDLE;
      r_limit    <= '1;
      r_down     <= 1'b0;
      r_periodic <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_cfg_take) begin
        r_limit    <= cfg_limit;
        r_down     <= cfg_down;
        r_periodic <= cfg_periodic;
      end
    end
  end

  counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk        (clk),
    .clear_n    (clear_n),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_load_val (w_start_val),
    .i_step     (w_step),
    .i_down     (r_down),
    .o_count    (w_count)
  );

  assign count = w_count;
  assign state = r_state;
  assign busy  = (r_state == ST_RUN) || (r_state == ST_HOLD);
  assign tick  = (r_state == ST_RUN) && w_at_term;
  assign done  = (r_state == ST_DONE);

endmodule
